// File: rtl/itf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | itf_pkg                                                              |
// | Shared widths and FSM state encodings for the ISA fetch interface.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package itf_pkg;

  localparam int PORT_WIDTH_DEF      = 128;
  localparam int DRAM_ADDR_WIDTH_DEF = 32;
  localparam int NUMWORD_WIDTH_DEF   = 16;
  localparam int BUF_ADDR_WIDTH_DEF  = 2;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_FETCH = 2'd1;
  localparam fetch_state_t ST_DRAIN = 2'd2;
  localparam fetch_state_t ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/isa_fetch_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isa_fetch_buf                                                        |
// | First-word-fall-through FIFO; a full buffer accepts a push when a    |
// | pop happens in the same cycle.                                       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module isa_fetch_buf #(
  parameter int WIDTH      = 128,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic                w_do_push;
  logic                w_do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign count     = r_wr_ptr - r_rd_ptr;
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (count == (ADDR_WIDTH + 1)'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign pop_data  = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= push_data;
    end
  end

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (ADDR_WIDTH + 1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (ADDR_WIDTH + 1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/isa_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isa_fetch                                                            |
// | Fetches NumWord ISA words from DRAM starting at BaseAddr and streams |
// | them in order to the CCU, with credit-limited outstanding reads.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module isa_fetch
  import itf_pkg::*;
#(
  parameter int PORT_WIDTH      = PORT_WIDTH_DEF,
  parameter int DRAM_ADDR_WIDTH = DRAM_ADDR_WIDTH_DEF,
  parameter int NUMWORD_WIDTH   = NUMWORD_WIDTH_DEF,
  parameter int BUF_ADDR_WIDTH  = BUF_ADDR_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       TOPITF_Start,
  input  logic [DRAM_ADDR_WIDTH-1:0] TOPITF_BaseAddr,
  input  logic [NUMWORD_WIDTH-1:0]   TOPITF_NumWord,
  output logic                       ITFTOP_Busy,
  output logic                       ITFTOP_Done,
  output logic [DRAM_ADDR_WIDTH-1:0] ITFDRAM_RdAddr,
  output logic                       ITFDRAM_RdAddrVld,
  input  logic                       DRAMITF_RdAddrRdy,
  input  logic [PORT_WIDTH-1:0]      DRAMITF_RdDat,
  input  logic                       DRAMITF_RdDatVld,
  output logic                       ITFDRAM_RdDatRdy,
  output logic [PORT_WIDTH-1:0]      ITFCCU_ISARdDat,
  output logic                       ITFCCU_ISARdDatVld,
  input  logic                       CCUITF_ISARdDatRdy
);

  localparam int CW    = NUMWORD_WIDTH + 1;
  localparam int DEPTH = 1 << BUF_ADDR_WIDTH;

  fetch_state_t              r_state;
  fetch_state_t              w_state_nxt;
  logic [DRAM_ADDR_WIDTH-1:0] r_addr;
  logic [CW-1:0]             r_num;
  logic [CW-1:0]             r_req_cnt;
  logic [CW-1:0]             r_acc_cnt;
  logic [CW-1:0]             r_outstanding;
  logic [CW-1:0]             w_inflight;
  logic [BUF_ADDR_WIDTH:0]   w_buf_count;
  logic                      w_buf_full;
  logic                      w_buf_empty;
  logic [PORT_WIDTH-1:0]     w_buf_data;
  logic                      w_start_ok;
  logic                      w_req_acc;
  logic                      w_resp;
  logic                      w_pop;
  logic                      w_last_req;
  logic                      w_last_pop;

  // Reads in flight plus words held must never exceed the buffer depth,
  // which is what lets the response channel stay permanently ready.
  assign w_inflight = r_outstanding + CW'(w_buf_count);
  assign w_start_ok = TOPITF_Start && (r_state == ST_IDLE);
  assign w_req_acc  = ITFDRAM_RdAddrVld && DRAMITF_RdAddrRdy;
  assign w_resp     = DRAMITF_RdDatVld && (r_outstanding != '0);
  assign w_pop      = ITFCCU_ISARdDatVld && CCUITF_ISARdDatRdy;
  assign w_last_req = w_req_acc && ((r_req_cnt + CW'(1)) == r_num);
  assign w_last_pop = w_pop && ((r_acc_cnt + CW'(1)) == r_num);

  assign ITFDRAM_RdAddr     = r_addr;
  assign ITFDRAM_RdDatRdy   = 1'b1;
  assign ITFCCU_ISARdDatVld = !w_buf_empty;
  assign ITFCCU_ISARdDat    = w_buf_empty ? '0 : w_buf_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_nxt = (TOPITF_NumWord == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: if (w_last_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_last_pop) w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Control outputs decoded from state and credit.
  always_comb begin
    ITFTOP_Busy       = (r_state != ST_IDLE);
    ITFTOP_Done       = (r_state == ST_DONE);
    ITFDRAM_RdAddrVld = (r_state == ST_FETCH) && (r_req_cnt < r_num) &&
                        (w_inflight < CW'(DEPTH));
  end

  // Address, request/accept counters and outstanding-read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr        <= '0;
      r_num         <= '0;
      r_req_cnt     <= '0;
      r_acc_cnt     <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_start_ok) begin
        r_addr    <= TOPITF_BaseAddr;
        r_num     <= {1'b0, TOPITF_NumWord};
        r_req_cnt <= '0;
        r_acc_cnt <= '0;
      end else begin
        if (w_req_acc) begin
          r_addr    <= r_addr + DRAM_ADDR_WIDTH'(1);
          r_req_cnt <= r_req_cnt + CW'(1);
        end
        if (w_pop) r_acc_cnt <= r_acc_cnt + CW'(1);
      end
      case ({w_req_acc, w_resp})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // A response with nothing outstanding is dropped; flag it in simulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(DRAMITF_RdDatVld && (r_outstanding == '0)));
    end
  end

  isa_fetch_buf #(
    .WIDTH      (PORT_WIDTH),
    .ADDR_WIDTH (BUF_ADDR_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (w_resp),
    .push_data (DRAMITF_RdDat),
    .pop       (w_pop),
    .pop_data  (w_buf_data),
    .full      (w_buf_full),
    .empty     (w_buf_empty),
    .count     (w_buf_count)
  );

  // Full is implied by the credit rule; kept for visibility only.
  logic w_unused;
  assign w_unused = w_buf_full;

endmodule
`default_nettype wire

// File: tb/tb_isa_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_isa_fetch                                                         |
// | Randomized bench: DRAM responder with random latency, random ready   |
// | patterns, and a queue-based reference of addresses and words.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_isa_fetch;

  localparam int PW = 128;
  localparam int AW = 32;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          TOPITF_Start;
  logic [AW-1:0] TOPITF_BaseAddr;
  logic [NW-1:0] TOPITF_NumWord;
  logic          ITFTOP_Busy;
  logic          ITFTOP_Done;
  logic [AW-1:0] ITFDRAM_RdAddr;
  logic          ITFDRAM_RdAddrVld;
  logic          DRAMITF_RdAddrRdy;
  logic [PW-1:0] DRAMITF_RdDat;
  logic          DRAMITF_RdDatVld;
  logic          ITFDRAM_RdDatRdy;
  logic [PW-1:0] ITFCCU_ISARdDat;
  logic          ITFCCU_ISARdDatVld;
  logic          CCUITF_ISARdDatRdy;

  always #5 clk = ~clk;

  isa_fetch dut (
    .clk                (clk),
    .rst                (rst),
    .TOPITF_Start       (TOPITF_Start),
    .TOPITF_BaseAddr    (TOPITF_BaseAddr),
    .TOPITF_NumWord     (TOPITF_NumWord),
    .ITFTOP_Busy        (ITFTOP_Busy),
    .ITFTOP_Done        (ITFTOP_Done),
    .ITFDRAM_RdAddr     (ITFDRAM_RdAddr),
    .ITFDRAM_RdAddrVld  (ITFDRAM_RdAddrVld),
    .DRAMITF_RdAddrRdy  (DRAMITF_RdAddrRdy),
    .DRAMITF_RdDat      (DRAMITF_RdDat),
    .DRAMITF_RdDatVld   (DRAMITF_RdDatVld),
    .ITFDRAM_RdDatRdy   (ITFDRAM_RdDatRdy),
    .ITFCCU_ISARdDat    (ITFCCU_ISARdDat),
    .ITFCCU_ISARdDatVld (ITFCCU_ISARdDatVld),
    .CCUITF_ISARdDatRdy (CCUITF_ISARdDatRdy)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  pend_t         pend[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [PW-1:0] exp_word_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_req, n_pop, done_cnt, vld_seen;
  bit active;
  int arr_pct, ccu_pct;

  bit            start_req;
  logic [AW-1:0] start_base;
  logic [NW-1:0] start_num;

  bit            ccu_stall_prev, addr_stall_prev;
  logic [PW-1:0] ccu_prev;
  logic [AW-1:0] addr_prev;

  // Memory contents: any fixed, address-unique pattern.
  function automatic logic [PW-1:0] dram_word(input logic [AW-1:0] a);
    return {a * 32'd3 + 32'd1, ~a, a ^ 32'h5A5A_5A5A, a};
  endfunction

  // One clock of environment: drive at the negedge, observe 1 unit later,
  // and account for the handshakes that complete on the coming posedge.
  task automatic step();
    @(negedge clk);
    TOPITF_Start    = start_req;
    TOPITF_BaseAddr = start_base;
    TOPITF_NumWord  = start_num;
    if (start_req && !active) begin
      active   = 1'b1;
      done_cnt = 0;
      n_req    = 0;
      n_pop    = 0;
      for (int i = 0; i < int'(start_num); i++) begin
        exp_addr_q.push_back(start_base + AW'(i));
        exp_word_q.push_back(dram_word(start_base + AW'(i)));
      end
    end
    start_req = 1'b0;
    DRAMITF_RdAddrRdy  = ($urandom_range(99) < arr_pct);
    CCUITF_ISARdDatRdy = ($urandom_range(99) < ccu_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      DRAMITF_RdDatVld = 1'b1;
      DRAMITF_RdDat    = dram_word(pend[0].addr);
    end else begin
      DRAMITF_RdDatVld = 1'b0;
      DRAMITF_RdDat    = '0;
    end
    #1;
    if (addr_stall_prev) begin
      vectors++;
      if (ITFDRAM_RdAddrVld !== 1'b1 || ITFDRAM_RdAddr !== addr_prev) begin
        miscompares++;
        $display("FAIL addr_hold: vld=%b addr=%h required vld=1 addr=%h",
                 ITFDRAM_RdAddrVld, ITFDRAM_RdAddr, addr_prev);
      end
    end
    addr_stall_prev = ITFDRAM_RdAddrVld && !DRAMITF_RdAddrRdy;
    addr_prev       = ITFDRAM_RdAddr;
    if (ITFDRAM_RdAddrVld === 1'b1) vld_seen++;
    if (ITFDRAM_RdAddrVld && DRAMITF_RdAddrRdy) begin
      vectors++;
      if (exp_addr_q.size() == 0) begin
        miscompares++;
        $display("FAIL req_addr: unexpected request addr=%h required none", ITFDRAM_RdAddr);
      end else begin
        logic [AW-1:0] ea;
        ea = exp_addr_q.pop_front();
        if (ITFDRAM_RdAddr !== ea) begin
          miscompares++;
          $display("FAIL req_addr: got %h required %h", ITFDRAM_RdAddr, ea);
        end
      end
      pend.push_back('{addr: ITFDRAM_RdAddr, due: cyc + 1 + int'($urandom_range(3))});
      n_req++;
    end
    if (DRAMITF_RdDatVld) begin
      vectors++;
      if (ITFDRAM_RdDatRdy !== 1'b1) begin
        miscompares++;
        $display("FAIL rddat_rdy: got %b required 1", ITFDRAM_RdDatRdy);
      end
      void'(pend.pop_front());
    end
    if (ccu_stall_prev) begin
      vectors++;
      if (ITFCCU_ISARdDatVld !== 1'b1 || ITFCCU_ISARdDat !== ccu_prev) begin
        miscompares++;
        $display("FAIL ccu_hold: vld=%b dat=%h required vld=1 dat=%h",
                 ITFCCU_ISARdDatVld, ITFCCU_ISARdDat, ccu_prev);
      end
    end
    ccu_stall_prev = ITFCCU_ISARdDatVld && !CCUITF_ISARdDatRdy;
    ccu_prev       = ITFCCU_ISARdDat;
    if (ITFCCU_ISARdDatVld && CCUITF_ISARdDatRdy) begin
      vectors++;
      if (exp_word_q.size() == 0) begin
        miscompares++;
        $display("FAIL ccu_word: unexpected word %h required none", ITFCCU_ISARdDat);
      end else begin
        logic [PW-1:0] ew;
        ew = exp_word_q.pop_front();
        if (ITFCCU_ISARdDat !== ew) begin
          miscompares++;
          $display("FAIL ccu_word: got %h required %h", ITFCCU_ISARdDat, ew);
        end
      end
      n_pop++;
    end
    if (ITFTOP_Done === 1'b1) begin
      done_cnt++;
      active = 1'b0;
    end
    if (active) begin
      vectors++;
      if (n_req - n_pop > 4) begin
        miscompares++;
        $display("FAIL credit: in flight %0d required <= 4", n_req - n_pop);
      end
    end
    cyc++;
  endtask

  task automatic kick(input logic [AW-1:0] base, input logic [NW-1:0] num);
    start_req  = 1'b1;
    start_base = base;
    start_num  = num;
    step();
  endtask

  // Run until Done, then confirm everything arrived and the block idles.
  task automatic wait_done(input int budget);
    int k = 0;
    while (active && k < budget) begin
      step();
      k++;
    end
    vectors++;
    if (active) begin
      miscompares++;
      $display("FAIL done_timeout: still active after %0d cycles required done", budget);
      active = 1'b0;
    end
    step();
    vectors++;
    if (exp_addr_q.size() != 0 || exp_word_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftovers: addr %0d words %0d required 0 0",
               exp_addr_q.size(), exp_word_q.size());
    end
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("FAIL done_count: got %0d required 1", done_cnt);
    end
    vectors++;
    if (ITFTOP_Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after: got %b required 0", ITFTOP_Busy);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst                = 1'b1;
    TOPITF_Start       = 1'b0;
    DRAMITF_RdAddrRdy  = 1'b0;
    CCUITF_ISARdDatRdy = 1'b0;
    DRAMITF_RdDatVld   = 1'b0;
    DRAMITF_RdDat      = '0;
    pend.delete();
    exp_addr_q.delete();
    exp_word_q.delete();
    active          = 1'b0;
    ccu_stall_prev  = 1'b0;
    addr_stall_prev = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (ITFDRAM_RdAddrVld !== 1'b0 || ITFCCU_ISARdDatVld !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_vld: rdaddrvld=%b isavld=%b required 0 0",
               ITFDRAM_RdAddrVld, ITFCCU_ISARdDatVld);
    end
    vectors++;
    if (ITFTOP_Busy !== 1'b0 || ITFTOP_Done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_busy_done: busy=%b done=%b required 0 0", ITFTOP_Busy, ITFTOP_Done);
    end
    vectors++;
    if (ITFDRAM_RdDatRdy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_rddatrdy: got %b required 1", ITFDRAM_RdDatRdy);
    end
    vectors++;
    if (ITFCCU_ISARdDat !== '0) begin
      miscompares++;
      $display("FAIL rst_isadat: got %h required 0", ITFCCU_ISARdDat);
    end
    vectors++;
    if (ITFDRAM_RdAddr !== '0) begin
      miscompares++;
      $display("FAIL rst_rdaddr: got %h required 0", ITFDRAM_RdAddr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic();
    arr_pct = 100;
    ccu_pct = 100;
    kick(32'h0000_0100, 16'd3);
    wait_done(200);
  endtask

  task automatic test_zero_words();
    arr_pct  = 100;
    ccu_pct  = 100;
    vld_seen = 0;
    kick(32'h0000_0040, 16'd0);
    step();
    // Done is seen in the cycle right after the one carrying Start.
    vectors++;
    if (ITFTOP_Done !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_done_timing: got %b required 1", ITFTOP_Done);
    end
    step();
    vectors++;
    if (ITFTOP_Busy !== 1'b0 || ITFTOP_Done !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_idle: busy=%b done=%b required 0 0", ITFTOP_Busy, ITFTOP_Done);
    end
    vectors++;
    if (vld_seen != 0 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL zero_noreq: vld cycles %0d done %0d required 0 1", vld_seen, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    arr_pct = 100;
    ccu_pct = 0;
    kick($urandom, 16'd8);
    repeat (20) step();
    vectors++;
    if (n_req != 4) begin
      miscompares++;
      $display("FAIL bp_requests: got %0d required 4", n_req);
    end
    vectors++;
    if (ITFDRAM_RdAddrVld !== 1'b0 || ITFCCU_ISARdDatVld !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_stall: rdaddrvld=%b isavld=%b required 0 1",
               ITFDRAM_RdAddrVld, ITFCCU_ISARdDatVld);
    end
    ccu_pct = 100;
    wait_done(200);
  endtask

  task automatic test_wrap();
    arr_pct = 70;
    ccu_pct = 70;
    kick(32'hFFFF_FFFE, 16'd3);
    wait_done(300);
  endtask

  task automatic test_ignore_start();
    arr_pct = 100;
    ccu_pct = 100;
    kick(32'h0000_0200, 16'd6);
    step();
    vectors++;
    if (ITFTOP_Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ign_busy: got %b required 1", ITFTOP_Busy);
    end
    kick(32'h0000_0500, 16'd5);
    wait_done(300);
  endtask

  task automatic test_reset_mid();
    int k = 0;
    arr_pct = 100;
    ccu_pct = 100;
    kick(32'h0000_0300, 16'd6);
    while (n_pop < 2 && k < 100) begin
      step();
      k++;
    end
    vectors++;
    if (n_pop < 2) begin
      miscompares++;
      $display("FAIL rstmid_progress: words %0d required 2", n_pop);
    end
    do_reset();
    kick(32'h0000_0700, 16'd1);
    wait_done(200);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      arr_pct = int'($urandom_range(100, 30));
      ccu_pct = int'($urandom_range(100, 30));
      kick($urandom, NW'($urandom_range(12, 1)));
      wait_done(600);
    end
  endtask

  initial begin
    rst                = 1'b1;
    TOPITF_Start       = 1'b0;
    TOPITF_BaseAddr    = '0;
    TOPITF_NumWord     = '0;
    DRAMITF_RdAddrRdy  = 1'b0;
    DRAMITF_RdDat      = '0;
    DRAMITF_RdDatVld   = 1'b0;
    CCUITF_ISARdDatRdy = 1'b0;
    start_req  = 1'b0;
    start_base = '0;
    start_num  = '0;
    active     = 1'b0;
    arr_pct    = 100;
    ccu_pct    = 100;
    n_req      = 0;
    n_pop      = 0;
    done_cnt   = 0;
    vld_seen   = 0;
    ccu_stall_prev  = 1'b0;
    addr_stall_prev = 1'b0;
    ccu_prev   = '0;
    addr_prev  = '0;
    repeat (2) @(posedge clk);

    test_reset();
    test_basic();
    test_zero_words();
    test_backpressure();
    test_wrap();
    test_ignore_start();
    test_reset_mid();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
